// File: rtl/tnn_accum_classifier.sv
// Purpose: accumulates N_IN unsigned operands per beat over a frame, saturating, then thresholds the sum into a class bit.
// Latency: result valid one cycle after the closing beat (in_last or beat MAX_BEATS) is accepted.
// Backpressure: in_ready low while a result waits; the result holds until out_ready; optional TNN_APPROX_LSB_EN zeroes operand bit 0.
module tnn_accum_classifier #(
  parameter int N_IN      = 7,
  parameter int W_IN      = 2,
  parameter int ACC_W     = 12,
  parameter int MAX_BEATS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*W_IN-1:0]   in_data,
  input  logic                   in_last,
  input  logic [ACC_W-1:0]       thresh,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_class,
  output logic [ACC_W-1:0]       out_sum,
  output logic                   out_trunc
);

  // Beat sum width holds N_IN * (2^W_IN - 1) without truncation.
  localparam int SUM_W = W_IN + $clog2(N_IN) + 1;
  // One extra bit over the wider operand so the saturation test sees the carry.
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [7:0]       BEAT_LIM = 8'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   thr_q, thr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               trunc_q, trunc_d;

  logic [SUM_W-1:0]   beat_sum;
  logic [W_IN-1:0]    op;
  logic [ACC_W-1:0]   acc_base;
  logic [EXT_W-1:0]   acc_ext;
  logic [7:0]         cnt_nxt;
  logic               beat_acc;
  logic               res_acc;
  logic               lim_hit;

  // Adder tree: full-width unsigned sum of every operand in the beat.
  always_comb begin
    beat_sum = '0;
    op       = '0;
    for (int k = 0; k < N_IN; k++) begin
      op = in_data[k*W_IN +: W_IN];
`ifdef TNN_APPROX_LSB_EN
      op[0] = 1'b0;
`endif
      beat_sum = beat_sum + SUM_W'(op);
    end
  end

  // Handshakes and result outputs; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready  = rst_n && (state_q != RESULT);
    out_valid = (state_q == RESULT);
    beat_acc  = in_valid && in_ready;
    res_acc   = out_valid && out_ready;
    out_sum   = acc_q;
    out_class = out_valid && (acc_q >= thr_q);
    out_trunc = trunc_q;
  end

  // Next-state: a first beat restarts the frame, later beats add with saturation.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    thr_d    = thr_q;
    cnt_d    = cnt_q;
    trunc_d  = trunc_q;
    acc_base = (state_q == IDLE) ? '0 : acc_q;
    acc_ext  = EXT_W'(acc_base) + EXT_W'(beat_sum);
    cnt_nxt  = (state_q == IDLE) ? 8'd1 : cnt_q + 8'd1;
    lim_hit  = (cnt_nxt == BEAT_LIM);

    if (beat_acc) begin
      acc_d = (acc_ext > EXT_W'(ACC_MAX)) ? ACC_MAX : acc_ext[ACC_W-1:0];
      cnt_d = cnt_nxt;
      if (state_q == IDLE) begin
        thr_d = thresh;
      end
      if (in_last || lim_hit) begin
        state_d = RESULT;
        trunc_d = !in_last && lim_hit;
      end else begin
        state_d = ACCUM;
      end
    end

    if (res_acc) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      trunc_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset discarding any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      thr_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

endmodule

// File: tb/tb_tnn_accum_classifier.sv
// Purpose: directed frames into a default instance and an ACC_W=6 instance, results checked by scoreboard monitors.
// Latency: checks out_valid one cycle after each closing beat.
// Backpressure: holds out_ready low on one frame to check in_ready and result stability.
module tb_tnn_accum_classifier;

  localparam int DW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_valid6, in_last, out_ready;
  logic [DW-1:0] in_data;
  logic [11:0]   thresh;
  logic [5:0]    thresh6;
  logic          in_ready, out_valid, out_class, out_trunc;
  logic [11:0]   out_sum;
  logic          in_ready6, out_valid6, out_class6, out_trunc6;
  logic [5:0]    out_sum6;

  tnn_accum_classifier #(.N_IN(7), .W_IN(2), .ACC_W(12), .MAX_BEATS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_sum(out_sum), .out_trunc(out_trunc)
  );

  tnn_accum_classifier #(.N_IN(7), .W_IN(2), .ACC_W(6), .MAX_BEATS(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
    .in_data(in_data), .in_last(in_last), .thresh(thresh6),
    .out_valid(out_valid6), .out_ready(out_ready), .out_class(out_class6),
    .out_sum(out_sum6), .out_trunc(out_trunc6)
  );

  typedef struct packed {
    logic [11:0] sum;
    logic        cls;
    logic        trunc;
  } exp_t;

  exp_t q[$];
  exp_t q6[$];
  int   cmp = 0;
  int   err = 0;

  task automatic check(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the default instance: compare on every result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        cmp++; err++;
        $display("FAIL unexpected_result: got sum %0d, expected no result", out_sum);
      end else begin
        e = q.pop_front();
        check("out_sum", int'(out_sum), int'(e.sum));
        check("out_class", int'(out_class), int'(e.cls));
        check("out_trunc", int'(out_trunc), int'(e.trunc));
      end
    end
  end

  // Monitor for the ACC_W=6 instance.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid6 && out_ready) begin
      if (q6.size() == 0) begin
        cmp++; err++;
        $display("FAIL unexpected_result6: got sum %0d, expected no result", out_sum6);
      end else begin
        e = q6.pop_front();
        check("out_sum6", int'(out_sum6), int'(e.sum));
        check("out_class6", int'(out_class6), int'(e.cls));
        check("out_trunc6", int'(out_trunc6), int'(e.trunc));
      end
    end
  end

  // Present one beat, wait (bounded) for acceptance, optionally check 1-cycle result latency.
  task automatic send(input bit six, input logic [DW-1:0] d, input bit last,
                      input int thr, input bit closing);
    int n;
    bit rdy;
    n = 0;
    in_data = d;
    in_last = last;
    thresh  = 12'(thr);
    thresh6 = 6'(thr);
    if (six) in_valid6 = 1'b1;
    else     in_valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
      rdy = six ? in_ready6 : in_ready;
    end while (!rdy && n < 50);
    if (!rdy) begin
      cmp++; err++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid6 = 1'b0;
    if (closing) check("latency_out_valid", int'(six ? out_valid6 : out_valid), 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_valid6 = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b1; thresh = '0; thresh6 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_class", int'(out_class), 0);
    check("rst_out_trunc", int'(out_trunc), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid6", int'(out_valid6), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

`ifdef TNN_APPROX_LSB_EN
    // All operands 3 -> each contributes 2: 7*2 = 14.
    q.push_back('{sum: 12'd14, cls: 1'b1, trunc: 1'b0});
    send(0, 14'h3FFF, 1, 14, 1);
`else
    // One beat of all 3s, thresh 21 -> 21, class 1.
    q.push_back('{sum: 12'd21, cls: 1'b1, trunc: 1'b0});
    send(0, 14'h3FFF, 1, 21, 1);

    // Sums 5, 6, 7; thresh 19 on first beat, later thresh changes ignored -> 18, class 0.
    q.push_back('{sum: 12'd18, cls: 1'b0, trunc: 1'b0});
    send(0, 14'h000B, 0, 19, 0);
    send(0, 14'h000F, 0, 0, 0);
    send(0, 14'h001F, 1, 0, 1);

    // Four beats of all 3s without in_last -> 84, truncated; result held under backpressure.
    q.push_back('{sum: 12'd84, cls: 1'b1, trunc: 1'b1});
    send(0, 14'h3FFF, 0, 84, 0);
    send(0, 14'h3FFF, 0, 0, 0);
    send(0, 14'h3FFF, 0, 0, 0);
    out_ready = 1'b0;
    send(0, 14'h3FFF, 0, 0, 1);
    in_valid = 1'b1; in_data = 14'h0001; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_out_sum", int'(out_sum), 84);
      check("hold_out_trunc", int'(out_trunc), 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("reready_in_ready", int'(in_ready), 1);
    check("reready_out_valid", int'(out_valid), 0);

    // in_last on beat 4 is not a truncation: 4 beats of 1 -> 4, thresh 4 -> class 1.
    q.push_back('{sum: 12'd4, cls: 1'b1, trunc: 1'b0});
    send(0, 14'h0001, 0, 4, 0);
    send(0, 14'h0001, 0, 0, 0);
    send(0, 14'h0001, 0, 0, 0);
    send(0, 14'h0001, 1, 0, 1);

    // Reset after two beats, then a one-beat frame of sum 4 with thresh 5.
    send(0, 14'h3FFF, 0, 0, 0);
    send(0, 14'h3FFF, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_sum", int'(out_sum), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    q.push_back('{sum: 12'd4, cls: 1'b0, trunc: 1'b0});
    send(0, 14'h0007, 1, 5, 1);

    // ACC_W=6: three beats of all 3s reach 63 exactly, thresh 63 -> class 1.
    q6.push_back('{sum: 12'd63, cls: 1'b1, trunc: 1'b0});
    send(1, 14'h3FFF, 0, 63, 0);
    send(1, 14'h3FFF, 0, 0, 0);
    send(1, 14'h3FFF, 1, 0, 1);

    // ACC_W=6: four beats (84) saturate to 63 and stay there; truncated frame.
    q6.push_back('{sum: 12'd63, cls: 1'b1, trunc: 1'b1});
    send(1, 14'h3FFF, 0, 63, 0);
    send(1, 14'h3FFF, 0, 0, 0);
    send(1, 14'h3FFF, 0, 0, 0);
    send(1, 14'h3FFF, 0, 0, 1);
`endif

    n = 0;
    while ((q.size() + q6.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drain", q.size() + q6.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/tnn_accum_classifier.md
TNN_ACCUM_CLASSIFIER -- requirements
Module: tnn_accum_classifier

Interface
REQ-001 SHALL have parameter N_IN, default 7: operands per input beat.
REQ-002 SHALL have parameter W_IN, default 2: unsigned operand width in bits.
REQ-003 SHALL have parameter ACC_W, default 12: accumulator, sum and threshold width.
REQ-004 SHALL have parameter MAX_BEATS, default 4: maximum beats per frame (legal range 1..255).
REQ-005 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, synchronous and active-low.
REQ-007 SHALL have port in_valid  in  1: input beat valid.
REQ-008 SHALL have port in_ready  out  1: block accepts a beat.
REQ-009 SHALL have port in_data  in  N_IN*W_IN: packed operands; operand k occupies bits [k*W_IN +: W_IN].
REQ-010 SHALL have port in_last  in  1: final beat of frame.
REQ-011 SHALL have port thresh  in  ACC_W: class threshold, sampled on the first accepted beat of each frame.
REQ-012 SHALL have port out_valid  out  1: result valid.
REQ-013 SHALL have port out_ready  in  1: consumer accepts result.
REQ-014 SHALL have port out_class  out  1: 1 when out_sum >= the sampled threshold.
REQ-015 SHALL have port out_sum  out  ACC_W: saturated frame sum.
REQ-016 SHALL have port out_trunc  out  1: frame closed by the beat limit, not by in_last.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM and RESULT.
REQ-018 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in RESULT.
REQ-019 SHALL accept a beat exactly on a cycle with in_valid and in_ready both high.
REQ-020 SHALL compute beat_sum as the unsigned sum of all N_IN operands at full width, with no internal truncation.
REQ-021 SHALL, on each accepted beat, set acc to min(acc + beat_sum, 2^ACC_W-1) (saturating).
REQ-022 SHALL, on an accepted beat in IDLE, load acc from beat_sum (saturated), capture thresh, set the beat count to 1, and go to ACCUM.
REQ-023 SHALL close a frame when the accepted beat has in_last=1 or is beat number MAX_BEATS, and move to RESULT on the next edge.
REQ-024 SHALL take in_last=1 on the first beat of a frame as a one-beat frame.
REQ-025 SHALL, with MAX_BEATS=1, close every frame after one beat.
REQ-026 SHALL set out_trunc=1 only when a frame closes on beat MAX_BEATS with in_last=0.
REQ-027 SHALL, in RESULT, assert out_valid and hold out_sum, out_class and out_trunc stable until out_valid and out_ready are both high.
REQ-028 SHALL, on the result handshake, clear acc and the beat count and return to IDLE; in_ready reasserts on the following cycle.
REQ-029 SHALL assert out_valid on the cycle after the closing beat is accepted (latency 1).
REQ-030 SHALL ignore in_valid, in_data and in_last while in RESULT.
REQ-031 SHALL ignore changes on thresh after the first beat of a frame.
REQ-032 SHALL keep acc saturated once it saturates; further beats do not wrap it.

Reset
REQ-033 SHALL, on clk with rst_n=0, go to IDLE and set acc=0, beat count=0, out_valid=0, out_sum=0, out_class=0, out_trunc=0 and in_ready=0.
REQ-034 SHALL discard any partial frame or pending result when reset is asserted mid-operation.
REQ-035 SHALL set in_ready=1 on the first cycle after rst_n returns high.

Configuration
REQ-036 SHALL support macro TNN_APPROX_LSB_EN: when defined, force bit 0 of every operand to 0 before summation (approximate, smaller adder tree).
REQ-037 SHALL, without TNN_APPROX_LSB_EN, sum every operand exactly; the handshake and FSM are identical in both builds.

Verification
REQ-038 SHALL pass this case (defaults, exact build): one beat of all operands = 3, in_last=1, thresh=21 -> the next cycle has out_valid=1, out_sum=21, out_class=1, out_trunc=0.
REQ-039 SHALL pass this case: three beats with sums 5, 6, 7 and in_last on beat 3, thresh=19 -> out_sum=18, out_class=0.
REQ-040 SHALL pass this case: four beats of all 3s with in_last=0 -> out_sum=84, out_trunc=1, and in_ready=0 until out_ready is high.
REQ-041 SHALL pass this case: ACC_W=6, three beats of all 3s -> out_sum=63 (saturated), out_class=1 with thresh=63.
REQ-042 SHALL pass this case: rst_n low for one cycle after two beats, then a one-beat frame of sum 4 -> out_sum=4, with no residue from the prior frame.
REQ-043 SHALL pass this case (TNN_APPROX_LSB_EN defined): one beat of all operands = 3 -> out_sum=14.
